// File: rtl/fsm_share_pkg.sv
// Shared types for the two-requester sequence-detector controller.
package fsm_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the registered pointer remembers the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] win
);

  logic last_q;

  // Reset to "last was 1" so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && (|win)) begin
      last_q <= win[1];
    end
  end

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last_q ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/fsm_share_ctrl.sv
// Shares one X/Y-in, Z-out detector FSM between two requesters: grant, drive the
// symbol, idle for a gap, then report whether Z was seen during the window.
module fsm_share_ctrl
  import fsm_share_pkg::*;
#(
  parameter int DRIVE_CYC = 1,
  parameter int GAP_CYC   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [1:0]       SYM0,
  input  logic             REQ1,
  input  logic [1:0]       SYM1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             HIT,
  output logic             FSM_X,
  output logic             FSM_Y,
  input  logic             FSM_Z,
  output logic             BUSY,
  output logic [CNT_W-1:0] HIT_CNT
);

  localparam int MAX_CYC = (DRIVE_CYC > GAP_CYC) ? DRIVE_CYC : GAP_CYC;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  sym_t             sym_q, sym_d;
  sym_t             drv_q, drv_d;
  logic             idx_q, idx_d;
  logic             hit_q, hit_d;
  logic             resp_hit_q, resp_hit_d;
  logic             busy_q, busy_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [1:0]       win;
  logic             advance;

  assign advance = (state_q == IDLE) && (REQ0 || REQ1);

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     ({REQ1, REQ0}),
    .advance (advance),
    .win     (win)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_d      = sym_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    drv_d      = SYM_IDLE;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    resp_hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (advance) begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = win[1];
          sym_d   = win[1] ? SYM1 : SYM0;
          drv_d   = sym_d;
          hit_d   = 1'b0;
          gnt_d   = win;
        end
      end
      DRIVE: begin
        hit_d = hit_q | FSM_Z;
        if (cnt_q == DRIVE_LAST) begin
          cnt_d = '0;
          if (GAP_CYC == 0) begin
            state_d    = RESP;
            done_d     = idx_q ? 2'b10 : 2'b01;
            resp_hit_d = hit_d;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          drv_d = sym_q;
        end
      end
      GAP: begin
        hit_d = hit_q | FSM_Z;
        if (cnt_q == GAP_LAST) begin
          cnt_d      = '0;
          state_d    = RESP;
          done_d     = idx_q ? 2'b10 : 2'b01;
          resp_hit_d = hit_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (resp_hit_q && !(&hit_cnt_q)) begin
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sym_q      <= SYM_IDLE;
      drv_q      <= SYM_IDLE;
      idx_q      <= 1'b0;
      hit_q      <= 1'b0;
      resp_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      hit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      drv_q      <= drv_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      resp_hit_q <= resp_hit_d;
      busy_q     <= busy_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  assign GNT0    = gnt_q[0];
  assign GNT1    = gnt_q[1];
  assign DONE0   = done_q[0];
  assign DONE1   = done_q[1];
  assign HIT     = resp_hit_q;
  assign FSM_X   = drv_q[1];
  assign FSM_Y   = drv_q[0];
  assign BUSY    = busy_q;
  assign HIT_CNT = hit_cnt_q;

endmodule

// File: tb/tb_fsm_share_ctrl.sv
// Directed bench for fsm_share_ctrl: default timing (A), DRIVE_CYC=3/GAP_CYC=0 (B),
// and a 2-bit saturating hit counter (C).
module tb_fsm_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters, stub FSM raises Z one cycle after X&Y
  logic       rst_a, req0_a, req1_a, z_a;
  logic [1:0] sym0_a, sym1_a;
  logic       gnt0_a, gnt1_a, done0_a, done1_a, hit_a, x_a, y_a, busy_a;
  logic [7:0] cnt_a;

  // Instance B: DRIVE_CYC=3, GAP_CYC=0, Z never high
  logic       rst_b, req0_b, req1_b, z_b;
  logic [1:0] sym0_b, sym1_b;
  logic       gnt0_b, gnt1_b, done0_b, done1_b, hit_b, x_b, y_b, busy_b;
  logic [7:0] cnt_b;

  // Instance C: CNT_W=2, same stub as A
  logic       rst_c, req0_c, req1_c, z_c;
  logic [1:0] sym0_c, sym1_c;
  logic       gnt0_c, gnt1_c, done0_c, done1_c, hit_c, x_c, y_c, busy_c;
  logic [1:0] cnt_c;

  assign z_b = 1'b0;
  always @(posedge clk) z_a <= x_a & y_a;
  always @(posedge clk) z_c <= x_c & y_c;

  fsm_share_ctrl u_dut_a (
    .CLK(clk), .RST(rst_a), .REQ0(req0_a), .SYM0(sym0_a), .REQ1(req1_a), .SYM1(sym1_a),
    .GNT0(gnt0_a), .GNT1(gnt1_a), .DONE0(done0_a), .DONE1(done1_a), .HIT(hit_a),
    .FSM_X(x_a), .FSM_Y(y_a), .FSM_Z(z_a), .BUSY(busy_a), .HIT_CNT(cnt_a)
  );

  fsm_share_ctrl #(.DRIVE_CYC(3), .GAP_CYC(0), .CNT_W(8)) u_dut_b (
    .CLK(clk), .RST(rst_b), .REQ0(req0_b), .SYM0(sym0_b), .REQ1(req1_b), .SYM1(sym1_b),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .DONE0(done0_b), .DONE1(done1_b), .HIT(hit_b),
    .FSM_X(x_b), .FSM_Y(y_b), .FSM_Z(z_b), .BUSY(busy_b), .HIT_CNT(cnt_b)
  );

  fsm_share_ctrl #(.DRIVE_CYC(1), .GAP_CYC(2), .CNT_W(2)) u_dut_c (
    .CLK(clk), .RST(rst_c), .REQ0(req0_c), .SYM0(sym0_c), .REQ1(req1_c), .SYM1(sym1_c),
    .GNT0(gnt0_c), .GNT1(gnt1_c), .DONE0(done0_c), .DONE1(done1_c), .HIT(hit_c),
    .FSM_X(x_c), .FSM_Y(y_c), .FSM_Z(z_c), .BUSY(busy_c), .HIT_CNT(cnt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req0_a = 0; req1_a = 0; sym0_a = 2'b00; sym1_a = 2'b00;
    req0_b = 0; req1_b = 0; sym0_b = 2'b00; sym1_b = 2'b00;
    req0_c = 0; req1_c = 0; sym0_c = 2'b00; sym1_c = 2'b00;
    tick(); tick();
    outs = {gnt0_a, gnt1_a, done0_a, done1_a, hit_a, x_a, y_a, busy_a};
    checks++;
    if (outs !== 8'h00 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: outs=%b cnt=%0d, expected outs=00000000 cnt=0", outs, cnt_a);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    outs = {gnt0_a, gnt1_a, done0_a, done1_a, hit_a, x_a, y_a, busy_a};
    checks++;
    if (outs !== 8'h00 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: outs=%b cnt=%0d, expected outs=00000000 cnt=0", outs, cnt_a);
    end
    checks++;
    if (cnt_b !== 8'd0 || cnt_c !== 2'd0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc: cnt_b=%0d cnt_c=%0d busy_b=%b busy_c=%b, expected all 0",
               cnt_b, cnt_c, busy_b, busy_c);
    end
    $display("txn reset: done");
  endtask

  task automatic test_back_to_back();
    int n;
    logic who;
    who = 1'b0;
    sym0_a = 2'b10; sym1_a = 2'b01;
    req0_a = 1'b1; req1_a = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (!(gnt0_a || gnt1_a) && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (n >= 10) begin
        errors++;
        $display("FAIL tie_grant_timeout: txn %0d no grant within %0d cycles", t, n);
      end
      if (t > 0) begin
        checks++;
        if (n !== 2) begin
          errors++;
          $display("FAIL tie_grant_spacing: txn %0d grant %0d cycles after DONE, expected 2", t, n);
        end
      end
      checks++;
      if ({gnt1_a, gnt0_a} !== (who ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL tie_grant_order: txn %0d gnt={%b,%b}, expected requester %0d",
                 t, gnt1_a, gnt0_a, who);
      end
      checks++;
      if ({x_a, y_a} !== (who ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL tie_drive_sym: txn %0d xy=%b%b, expected %b", t, x_a, y_a,
                 (who ? 2'b01 : 2'b10));
      end
      n = 0;
      do begin
        tick();
        n++;
      end while (!(done0_a || done1_a) && n < 10);
      if (t == 3) begin
        req0_a = 1'b0; req1_a = 1'b0;
      end
      checks++;
      if (n !== 3) begin
        errors++;
        $display("FAIL tie_done_latency: txn %0d DONE %0d cycles after grant, expected 3", t, n);
      end
      checks++;
      if ({done1_a, done0_a} !== (who ? 2'b10 : 2'b01) || hit_a !== 1'b0) begin
        errors++;
        $display("FAIL tie_done: txn %0d done={%b,%b} hit=%b, expected requester %0d hit=0",
                 t, done1_a, done0_a, hit_a, who);
      end
      $display("txn tie %0d: granted %0d, done after %0d cycles", t, who, n);
      who = ~who;
    end
    tick(); tick();
  endtask

  task automatic test_single();
    sym0_a = 2'b11; req0_a = 1'b1;
    tick();
    req0_a = 1'b0; sym0_a = 2'b00;
    checks++;
    if ({gnt0_a, gnt1_a, x_a, y_a, busy_a} !== 5'b10111) begin
      errors++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b xy=%b%b busy=%b, expected 1 0 11 1",
               gnt0_a, gnt1_a, x_a, y_a, busy_a);
    end
    tick();
    checks++;
    if ({gnt0_a, x_a, y_a, done0_a} !== 4'b0000) begin
      errors++;
      $display("FAIL single_gap1: gnt0=%b xy=%b%b done0=%b, expected 0 00 0", gnt0_a, x_a, y_a, done0_a);
    end
    tick();
    checks++;
    if ({x_a, y_a, done0_a, busy_a} !== 4'b0001) begin
      errors++;
      $display("FAIL single_gap2: xy=%b%b done0=%b busy=%b, expected 00 0 1", x_a, y_a, done0_a, busy_a);
    end
    tick();
    checks++;
    if ({done0_a, done1_a, hit_a} !== 3'b101) begin
      errors++;
      $display("FAIL single_done: done0=%b done1=%b hit=%b, expected 1 0 1", done0_a, done1_a, hit_a);
    end
    tick();
    checks++;
    if ({done0_a, hit_a, busy_a} !== 3'b000 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL single_after: done0=%b hit=%b busy=%b cnt=%0d, expected 0 0 0 cnt=1",
               done0_a, hit_a, busy_a, cnt_a);
    end
    $display("txn single: hit_cnt=%0d", cnt_a);
  endtask

  task automatic test_reset_mid();
    logic [7:0] outs;
    logic       saw_done;
    sym0_a = 2'b11; req0_a = 1'b1;
    tick();
    req0_a = 1'b0;
    #2 rst_a = 1'b1;
    #1;
    outs = {gnt0_a, gnt1_a, done0_a, done1_a, hit_a, x_a, y_a, busy_a};
    checks++;
    if (outs !== 8'h00 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_async: outs=%b cnt=%0d, expected outs=00000000 cnt=0", outs, cnt_a);
    end
    tick();
    rst_a = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done0_a || done1_a || busy_a) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: saw DONE/BUSY after abort=%b, expected 0", saw_done);
    end
    sym0_a = 2'b10; sym1_a = 2'b01;
    req0_a = 1'b1; req1_a = 1'b1;
    tick();
    req0_a = 1'b0; req1_a = 1'b0;
    checks++;
    if ({gnt1_a, gnt0_a} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_tie: gnt={%b,%b}, expected requester 0", gnt1_a, gnt0_a);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (cnt_a !== 8'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cnt: cnt=%0d busy=%b, expected cnt=0 busy=0", cnt_a, busy_a);
    end
    $display("txn reset_mid: first tie after reset to requester 0");
  endtask

  task automatic test_withdrawn();
    logic saw_gnt0;
    saw_gnt0 = 1'b0;
    sym1_a = 2'b01; req1_a = 1'b1;
    tick();
    if (gnt0_a) saw_gnt0 = 1'b1;
    req1_a = 1'b0;
    checks++;
    if (gnt1_a !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_first_grant: gnt1=%b, expected 1", gnt1_a);
    end
    tick();
    if (gnt0_a) saw_gnt0 = 1'b1;
    req0_a = 1'b1;
    tick();
    if (gnt0_a) saw_gnt0 = 1'b1;
    req0_a = 1'b0;
    req1_a = 1'b1;
    tick();
    if (gnt0_a) saw_gnt0 = 1'b1;
    checks++;
    if ({done1_a, hit_a} !== 2'b10) begin
      errors++;
      $display("FAIL withdraw_done1: done1=%b hit=%b, expected 1 0", done1_a, hit_a);
    end
    tick();
    if (gnt0_a) saw_gnt0 = 1'b1;
    checks++;
    if ({gnt1_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL withdraw_idle: gnt1=%b busy=%b, expected 0 0", gnt1_a, busy_a);
    end
    tick();
    if (gnt0_a) saw_gnt0 = 1'b1;
    req1_a = 1'b0;
    checks++;
    if (gnt1_a !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_regrant: gnt1=%b, expected 1 in first cycle after IDLE", gnt1_a);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gnt0_a) saw_gnt0 = 1'b1;
    end
    checks++;
    if (saw_gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_no_gnt0: saw GNT0=%b, expected 0", saw_gnt0);
    end
    checks++;
    if (cnt_a !== 8'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_cnt: cnt=%0d busy=%b, expected cnt=0 busy=0", cnt_a, busy_a);
    end
    $display("txn withdrawn: requester 1 served twice, no GNT0");
  endtask

  task automatic test_gap0();
    sym1_b = 2'b01; req1_b = 1'b1;
    tick();
    req1_b = 1'b0; sym1_b = 2'b10;
    checks++;
    if ({gnt1_b, gnt0_b, x_b, y_b} !== 4'b1001) begin
      errors++;
      $display("FAIL gap0_grant: gnt1=%b gnt0=%b xy=%b%b, expected 1 0 01", gnt1_b, gnt0_b, x_b, y_b);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt1_b, x_b, y_b, done1_b} !== 4'b0010) begin
        errors++;
        $display("FAIL gap0_drive: cycle %0d gnt1=%b xy=%b%b done1=%b, expected 0 01 0",
                 i, gnt1_b, x_b, y_b, done1_b);
      end
    end
    tick();
    checks++;
    if ({done1_b, done0_b, hit_b, x_b, y_b} !== 5'b10000) begin
      errors++;
      $display("FAIL gap0_done: done1=%b done0=%b hit=%b xy=%b%b, expected 1 0 0 00",
               done1_b, done0_b, hit_b, x_b, y_b);
    end
    tick();
    checks++;
    if (cnt_b !== 8'd0 || busy_b !== 1'b0 || done1_b !== 1'b0) begin
      errors++;
      $display("FAIL gap0_after: cnt=%0d busy=%b done1=%b, expected 0 0 0", cnt_b, busy_b, done1_b);
    end
    $display("txn gap0: DONE1 at cycle 3, hit=0");
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      sym0_c = 2'b11; req0_c = 1'b1;
      tick();
      req0_c = 1'b0;
      checks++;
      if ({gnt0_c, gnt1_c, busy_c} !== 3'b101) begin
        errors++;
        $display("FAIL sat_grant: txn %0d gnt0=%b gnt1=%b busy=%b, expected 1 0 1",
                 i, gnt0_c, gnt1_c, busy_c);
      end
      tick(); tick(); tick();
      checks++;
      if ({done0_c, done1_c, hit_c} !== 3'b101) begin
        errors++;
        $display("FAIL sat_done: txn %0d done0=%b done1=%b hit=%b, expected 1 0 1",
                 i, done0_c, done1_c, hit_c);
      end
      tick();
      checks++;
      if (cnt_c !== exp_cnt) begin
        errors++;
        $display("FAIL sat_count: txn %0d hit_cnt=%0d, expected %0d", i, cnt_c, exp_cnt);
      end
      $display("txn saturate %0d: hit_cnt=%0d", i, cnt_c);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_reset_mid();
    test_withdrawn();
    test_gap0();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
